// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Package bcd_pkg: shared constants, FSM state type and digit-validity helper
// for the serial packed-BCD adder controller.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [3:0]  BCD_MAX     = 4'd9;
  localparam logic [3:0]  BCD_CORR    = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } bcd_state_e;

  function automatic logic is_bad_digit(input logic [3:0] d);
    return (d > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Requester <-> controller bundle for bcd_serial_add_ctrl.
//   master (requester): drives start, a, b, c_in (and sub when BCD_SUB_EN)
//   slave  (controller): drives busy, done, sum, c_out, err
// Optional feature macro: BCD_SUB_EN adds the 1-bit sub request.
interface bcd_serial_add_ctrl_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  c_in;
`ifdef BCD_SUB_EN
  logic                  sub;
`endif
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  c_out;
  logic                  err;

  modport master (
    output start, a, b, c_in,
`ifdef BCD_SUB_EN
    output sub,
`endif
    input  busy, done, sum, c_out, err
  );

  modport slave (
    input  start, a, b, c_in,
`ifdef BCD_SUB_EN
    input  sub,
`endif
    output busy, done, sum, c_out, err
  );
endinterface

// File: rtl/bcd_serial_add_ctrl_digit_add.sv
// bcd_digit_add: combinational one-digit BCD adder.
//   a, b : BCD digits      ci : decimal carry in
//   d    : result digit    co : decimal carry out
// Invalid inputs follow the same rule on the 5-bit binary sum.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] d,
  output logic       co
);

  logic [4:0] w_s;
  logic [3:0] w_adj;

  always_comb begin
    w_s   = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    // (s+6)[3:0] equals s[3:0]+6 modulo 16.
    w_adj = w_s[3:0] + BCD_CORR;
    if (w_s > {1'b0, BCD_MAX}) begin
      d  = w_adj;
      co = 1'b1;
    end else begin
      d  = w_s[3:0];
      co = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl: packed-BCD adder that reuses one digit adder across
// DIGITS digits, LSD first, one digit per clock.
//   clk, rst_n : clock, synchronous active-low reset
//   bus (slave): start/a/b/c_in in; busy/done/sum/c_out/err out
// Optional feature macro: BCD_SUB_EN (sub=1 computes ten's-complement a-b).
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_serial_add_ctrl_if.slave bus
);

  localparam int unsigned      W        = BCD_DIGIT_W * DIGITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  bcd_state_e       r_state;
  bcd_state_e       w_next;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_sum;
  logic [W-1:0]     w_b_cap;
  logic             r_carry;
  logic             r_c_out;
  logic             r_err;
  logic [IDX_W-1:0] r_idx;
  logic             w_carry_init;
  logic             w_bad;
  logic             w_last;
  logic             w_accept;
  logic [3:0]       w_da;
  logic [3:0]       w_db;
  logic [3:0]       w_d;
  logic             w_co;

  assign w_accept = (r_state == IDLE) && bus.start;
  assign w_last   = (r_idx == LAST_IDX);

  // err always reflects the raw operands, even when b is complemented.
  always_comb begin
    w_bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      w_bad = w_bad
            | is_bad_digit(bus.a[BCD_DIGIT_W*i +: BCD_DIGIT_W])
            | is_bad_digit(bus.b[BCD_DIGIT_W*i +: BCD_DIGIT_W]);
    end
  end

`ifdef BCD_SUB_EN
  always_comb begin
    w_b_cap      = bus.b;
    w_carry_init = bus.c_in;
    if (bus.sub) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        w_b_cap[BCD_DIGIT_W*i +: BCD_DIGIT_W] = BCD_MAX - bus.b[BCD_DIGIT_W*i +: BCD_DIGIT_W];
      end
      w_carry_init = 1'b1;
    end
  end
`else
  assign w_b_cap      = bus.b;
  assign w_carry_init = bus.c_in;
`endif

  always_comb begin
    w_da = r_a[BCD_DIGIT_W*r_idx +: BCD_DIGIT_W];
    w_db = r_b[BCD_DIGIT_W*r_idx +: BCD_DIGIT_W];
  end

  bcd_digit_add u_digit_add (
    .a  (w_da),
    .b  (w_db),
    .ci (r_carry),
    .d  (w_d),
    .co (w_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_next = ADD;
      ADD:     if (w_last)    w_next = DONE;
      DONE:                   w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_c_out <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= w_b_cap;
      r_err   <= w_bad;
      r_sum   <= '0;
      r_c_out <= 1'b0;
      r_idx   <= '0;
      r_carry <= w_carry_init;
    end else if (r_state == ADD) begin
      r_sum[BCD_DIGIT_W*r_idx +: BCD_DIGIT_W] <= w_d;
      r_carry <= w_co;
      if (w_last) begin
        r_c_out <= w_co;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign bus.busy  = (r_state != IDLE);
  assign bus.done  = (r_state == DONE);
  assign bus.sum   = r_sum;
  assign bus.c_out = r_c_out;
  assign bus.err   = r_err;

endmodule
